// File: rtl/udma_uart_pkg.sv
// -----------------------------------------------------------------------------
// udma_uart_pkg
// Shared definitions for the uDMA UART TX byte feeder:
//   - datasize encodings carried alongside each uDMA word
//   - unpacker FSM state type
//   - helper turning a datasize code into a byte count
// -----------------------------------------------------------------------------
package udma_uart_pkg;

    localparam logic [1:0] UART_DS_BYTE = 2'd0;
    localparam logic [1:0] UART_DS_HALF = 2'd1;
    localparam logic [1:0] UART_DS_WORD = 2'd2;

    typedef enum logic {
        UP_IDLE,
        UP_SHIFT
    } up_state_e;

    // Code 3 is treated like a full word.
    function automatic logic [2:0] dsToLen(input logic [1:0] ds);
        logic [2:0] len;
        case (ds)
            UART_DS_BYTE: len = 3'd1;
            UART_DS_HALF: len = 3'd2;
            default:      len = 3'd4;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/udma_uart_byte_fifo.sv
// -----------------------------------------------------------------------------
// udma_uart_byte_fifo
// Small synchronous FIFO between the word unpacker and the UART serialiser.
// Ports:
//   clk_i, rstn_i    clock, async active-low reset
//   clr_i            synchronous clear of pointers and count
//   push_i, data_i   write request and data (ignored while full)
//   pop_i            read request (ignored while empty)
//   data_o           entry at the read pointer
//   full_o, empty_o  status derived from the registered pointers
//   count_o          number of entries held
// -----------------------------------------------------------------------------
module udma_uart_byte_fifo #(
    parameter int DEPTH     = 8,
    parameter int WIDTH     = 8,
    parameter int LOG_DEPTH = $clog2(DEPTH)
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 clr_i,
    input  logic                 push_i,
    input  logic [WIDTH-1:0]     data_i,
    input  logic                 pop_i,
    output logic [WIDTH-1:0]     data_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic [LOG_DEPTH:0]   count_o
);

    localparam logic [LOG_DEPTH:0] PTR_ONE = 1;

    logic [WIDTH-1:0]   mem [DEPTH];
    logic [LOG_DEPTH:0] wrPtr_q, wrPtr_d;
    logic [LOG_DEPTH:0] rdPtr_q, rdPtr_d;
    logic [LOG_DEPTH:0] count_q, count_d;
    logic               pushEn;
    logic               popEn;

    // The extra pointer bit tells a full FIFO apart from an empty one when
    // the address bits coincide.
    assign full_o  = (wrPtr_q[LOG_DEPTH] != rdPtr_q[LOG_DEPTH]) &&
                     (wrPtr_q[LOG_DEPTH-1:0] == rdPtr_q[LOG_DEPTH-1:0]);
    assign empty_o = (wrPtr_q == rdPtr_q);

    // Push looks only at the registered full flag, so a pop in the same cycle
    // does not open a slot until the next cycle.
    assign pushEn  = push_i && !full_o && !clr_i;
    assign popEn   = pop_i && !empty_o && !clr_i;

    assign data_o  = mem[rdPtr_q[LOG_DEPTH-1:0]];
    assign count_o = count_q;

    // Next-state for pointers and count; a clear wins over any traffic.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (clr_i) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else begin
            if (pushEn) begin
                wrPtr_d = wrPtr_q + PTR_ONE;
            end
            if (popEn) begin
                rdPtr_d = rdPtr_q + PTR_ONE;
            end
            if (pushEn && !popEn) begin
                count_d = count_q + PTR_ONE;
            end else if (popEn && !pushEn) begin
                count_d = count_q - PTR_ONE;
            end
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Storage array; deliberately not reset, its contents only matter once
    // the pointers say an entry is valid.
    always_ff @(posedge clk_i) begin
        if (pushEn) begin
            mem[wrPtr_q[LOG_DEPTH-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/udma_uart_tx_feeder.sv
// -----------------------------------------------------------------------------
// udma_uart_tx_feeder
// Splits uDMA TX words (1, 2 or 4 bytes, LSB first) into bytes and feeds them
// through a byte FIFO to the UART serialiser handshake.
// Ports:
//   clk_i, rstn_i          clock, async active-low reset
//   cfg_en_i               TX enable; low flushes everything buffered
//   data_tx_*              uDMA word channel (valid/ready)
//   tx_data_o/valid/ready  byte channel to the serialiser
//   tx_busy_i              serialiser not idle
//   fifo_count_o           bytes in the FIFO
//   busy_o                 unpacker loaded, FIFO non-empty or serialiser busy
// -----------------------------------------------------------------------------
module udma_uart_tx_feeder
    import udma_uart_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int LOG_DEPTH = $clog2(DEPTH)
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 cfg_en_i,
    input  logic [31:0]          data_tx_i,
    input  logic [1:0]           data_tx_datasize_i,
    input  logic                 data_tx_valid_i,
    output logic                 data_tx_ready_o,
    output logic [7:0]           tx_data_o,
    output logic                 tx_valid_o,
    input  logic                 tx_ready_i,
    input  logic                 tx_busy_i,
    output logic [LOG_DEPTH:0]   fifo_count_o,
    output logic                 busy_o
);

    up_state_e   state_q, state_d;
    logic [31:0] word_q, word_d;
    logic [2:0]  left_q, left_d;
    logic        bytePush;
    logic        fifoFull;
    logic        fifoEmpty;

    // Unpacker next-state. A word is only taken in UP_IDLE, so there is a
    // dead cycle between words; this keeps the accept path trivial.
    always_comb begin
        state_d         = state_q;
        word_d          = word_q;
        left_d          = left_q;
        data_tx_ready_o = 1'b0;
        bytePush        = 1'b0;
        if (!cfg_en_i) begin
            state_d = UP_IDLE;
            left_d  = 3'd0;
        end else begin
            case (state_q)
                UP_IDLE: begin
                    data_tx_ready_o = 1'b1;
                    if (data_tx_valid_i) begin
                        word_d  = data_tx_i;
                        left_d  = dsToLen(data_tx_datasize_i);
                        state_d = UP_SHIFT;
                    end
                end
                UP_SHIFT: begin
                    if (!fifoFull) begin
                        bytePush = 1'b1;
                        word_d   = {8'h00, word_q[31:8]};
                        left_d   = left_q - 3'd1;
                        if (left_q == 3'd1) begin
                            state_d = UP_IDLE;
                        end
                    end
                end
                default: begin
                    state_d = UP_IDLE;
                end
            endcase
        end
    end

    // Unpacker registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= UP_IDLE;
            word_q  <= '0;
            left_q  <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            left_q  <= left_d;
        end
    end

    udma_uart_byte_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .clr_i   (!cfg_en_i),
        .push_i  (bytePush),
        .data_i  (word_q[7:0]),
        .pop_i   (tx_valid_o && tx_ready_i),
        .data_o  (tx_data_o),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty),
        .count_o (fifo_count_o)
    );

    assign tx_valid_o = !fifoEmpty && cfg_en_i;
    assign busy_o     = (state_q == UP_SHIFT) || !fifoEmpty || tx_busy_i;

endmodule

// File: tb/tb_udma_uart_tx_feeder.sv
// -----------------------------------------------------------------------------
// tb_udma_uart_tx_feeder
// Scoreboard bench: accepted words are expanded into expected bytes in a
// queue; a negedge monitor pops and compares every byte handshake.
// -----------------------------------------------------------------------------
module tb_udma_uart_tx_feeder;

    logic        clk_i;
    logic        rstn_i;
    logic        cfg_en_i;
    logic [31:0] data_tx_i;
    logic [1:0]  data_tx_datasize_i;
    logic        data_tx_valid_i;
    logic        data_tx_ready_o;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i;
    logic        tx_busy_i;
    logic [3:0]  fifo_count_o;
    logic        busy_o;

    logic [7:0]  expQ[$];
    int          total;
    int          bad;
    bit          randReady;

    udma_uart_tx_feeder #(.DEPTH(8)) dut (
        .clk_i              (clk_i),
        .rstn_i             (rstn_i),
        .cfg_en_i           (cfg_en_i),
        .data_tx_i          (data_tx_i),
        .data_tx_datasize_i (data_tx_datasize_i),
        .data_tx_valid_i    (data_tx_valid_i),
        .data_tx_ready_o    (data_tx_ready_o),
        .tx_data_o          (tx_data_o),
        .tx_valid_o         (tx_valid_o),
        .tx_ready_i         (tx_ready_i),
        .tx_busy_i          (tx_busy_i),
        .fifo_count_o       (fifo_count_o),
        .busy_o             (busy_o)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Hard stop in case something wedges the stimulus.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    // Offer one word and hold it until it is accepted (bounded).
    task automatic applyStimulus(input logic [31:0] word, input logic [1:0] ds);
        bit acc;
        acc                = 1'b0;
        data_tx_i          = word;
        data_tx_datasize_i = ds;
        data_tx_valid_i    = 1'b1;
        for (int i = 0; i < 100; i++) begin
            #1;
            acc = data_tx_ready_o;
            tick();
            if (acc) break;
        end
        data_tx_valid_i = 1'b0;
        if (!acc) checkOutput("accept_timeout", 32'd0, 32'd1);
    endtask

    // Wait for every expected byte to leave and the block to go idle.
    task automatic waitDrain();
        for (int i = 0; i < 300; i++) begin
            if (expQ.size() == 0 && !busy_o) break;
            tick();
        end
        checkOutput("drain_queue", expQ.size(), 32'd0);
        checkOutput("drain_busy", {31'd0, busy_o}, 32'd0);
        checkOutput("drain_count", {28'd0, fifo_count_o}, 32'd0);
    endtask

    // Reference behaviour: an accepted word yields its low 1/2/4 bytes in
    // ascending order; a disabled cycle discards anything not yet sent.
    always @(negedge clk_i) begin
        if (rstn_i) begin
            if (!cfg_en_i) begin
                expQ.delete();
            end else begin
                if (tx_valid_o && tx_ready_i) begin
                    if (expQ.size() == 0) begin
                        checkOutput("unexpected_byte", {24'd0, tx_data_o}, 32'hFFFF_FFFF);
                    end else begin
                        checkOutput("byte_data", {24'd0, tx_data_o}, {24'd0, expQ.pop_front()});
                    end
                end
                if (data_tx_valid_i && data_tx_ready_o) begin
                    int len;
                    len = (data_tx_datasize_i == 2'd0) ? 1 : (data_tx_datasize_i == 2'd1) ? 2 : 4;
                    for (int b = 0; b < len; b++) begin
                        expQ.push_back(data_tx_i[8*b +: 8]);
                    end
                end
            end
        end
    end

    // Random backpressure from the serialiser during the random phase.
    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            if (randReady) tx_ready_i = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        total              = 0;
        bad                = 0;
        randReady          = 1'b0;
        rstn_i             = 1'b1;
        cfg_en_i           = 1'b0;
        data_tx_i          = '0;
        data_tx_datasize_i = '0;
        data_tx_valid_i    = 1'b0;
        tx_ready_i         = 1'b0;
        tx_busy_i          = 1'b0;
        #1 rstn_i = 1'b0;
        #2;

        // Reset state.
        checkOutput("rst_valid", {31'd0, tx_valid_o}, 32'd0);
        checkOutput("rst_count", {28'd0, fifo_count_o}, 32'd0);
        checkOutput("rst_ready", {31'd0, data_tx_ready_o}, 32'd0);
        tx_busy_i = 1'b1;
        #1 checkOutput("rst_busy_hi", {31'd0, busy_o}, 32'd1);
        tx_busy_i = 1'b0;
        #1 checkOutput("rst_busy_lo", {31'd0, busy_o}, 32'd0);
        tick();
        tick();
        rstn_i     = 1'b1;
        cfg_en_i   = 1'b1;
        tx_ready_i = 1'b1;
        #1 checkOutput("en_ready", {31'd0, data_tx_ready_o}, 32'd1);

        // Word split and accept-to-valid latency.
        applyStimulus(32'hA1B2_C3D4, 2'd2);
        checkOutput("lat_edge1_valid", {31'd0, tx_valid_o}, 32'd0);
        tick();
        checkOutput("lat_edge2_valid", {31'd0, tx_valid_o}, 32'd1);
        checkOutput("lat_first_byte", {24'd0, tx_data_o}, 32'hD4);
        waitDrain();

        // Transfer sizes.
        applyStimulus(32'h0000_005A, 2'd0);
        waitDrain();
        applyStimulus(32'h0000_BEEF, 2'd1);
        waitDrain();
        applyStimulus(32'h1122_3344, 2'd3);
        waitDrain();

        // Random words with random serialiser backpressure.
        randReady = 1'b1;
        for (int w = 0; w < 40; w++) begin
            applyStimulus($urandom, 2'($urandom_range(0, 3)));
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
        end
        randReady  = 1'b0;
        #2;
        tx_ready_i = 1'b1;
        waitDrain();

        // Full FIFO: 8 bytes buffered, 4 held in the unpacker.
        tx_ready_i = 1'b0;
        applyStimulus(32'h0302_0100, 2'd2);
        applyStimulus(32'h0706_0504, 2'd2);
        applyStimulus(32'h0B0A_0908, 2'd2);
        tick();
        checkOutput("full_count", {28'd0, fifo_count_o}, 32'd8);
        checkOutput("full_ready", {31'd0, data_tx_ready_o}, 32'd0);
        checkOutput("full_busy", {31'd0, busy_o}, 32'd1);
        tick();
        tick();
        checkOutput("full_hold_count", {28'd0, fifo_count_o}, 32'd8);
        tx_ready_i = 1'b1;
        tick();
        checkOutput("full_pop_count", {28'd0, fifo_count_o}, 32'd7);
        tx_ready_i = 1'b0;
        tick();
        checkOutput("full_refill_count", {28'd0, fifo_count_o}, 32'd8);
        tx_ready_i = 1'b1;
        waitDrain();

        // Simultaneous push and pop at count 3.
        tx_ready_i = 1'b0;
        applyStimulus(32'hDDCC_BBAA, 2'd2);
        tick();
        tick();
        tick();
        checkOutput("pp_count_before", {28'd0, fifo_count_o}, 32'd3);
        tx_ready_i = 1'b1;
        tick();
        checkOutput("pp_count_after", {28'd0, fifo_count_o}, 32'd3);
        waitDrain();

        // Flush with 5 bytes buffered and 2 in the unpacker.
        tx_ready_i = 1'b0;
        applyStimulus(32'h0000_0011, 2'd0);
        applyStimulus(32'h0000_3322, 2'd1);
        applyStimulus(32'h7766_5544, 2'd2);
        tick();
        tick();
        checkOutput("flush_pre_count", {28'd0, fifo_count_o}, 32'd5);
        cfg_en_i = 1'b0;
        tick();
        checkOutput("flush_count", {28'd0, fifo_count_o}, 32'd0);
        checkOutput("flush_valid", {31'd0, tx_valid_o}, 32'd0);
        checkOutput("flush_ready", {31'd0, data_tx_ready_o}, 32'd0);
        checkOutput("flush_busy_lo", {31'd0, busy_o}, 32'd0);
        tx_busy_i = 1'b1;
        #1 checkOutput("flush_busy_hi", {31'd0, busy_o}, 32'd1);
        tx_busy_i = 1'b0;
        tick();
        cfg_en_i   = 1'b1;
        tx_ready_i = 1'b1;
        applyStimulus(32'hCAFE_F00D, 2'd2);
        waitDrain();

        // Reset in the middle of a word.
        applyStimulus(32'h9988_7766, 2'd2);
        tick();
        rstn_i = 1'b0;
        expQ.delete();
        #1;
        checkOutput("mid_rst_valid", {31'd0, tx_valid_o}, 32'd0);
        checkOutput("mid_rst_count", {28'd0, fifo_count_o}, 32'd0);
        tick();
        tick();
        rstn_i = 1'b1;
        applyStimulus(32'h5566_7788, 2'd1);
        waitDrain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
